// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32M multiply/divide unit.
// Processes one operand bit per cycle (shift-add multiply, restoring divide).
// Valid/ready handshakes on request and response, and a kill input for flushes.
module rv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_nxt;

    // Operation context captured at accept
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q;      // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   mag_b_q;    // multiplicand / divisor magnitude
    logic              neg_q;      // negate product / quotient in FIX
    logic              neg_rem_q;  // remainder takes the sign of a
    logic [CW-1:0]     cnt_q;

    // Request decode
    logic            a_signed, b_signed;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_special;
    logic [XLEN-1:0] special_data;
    logic            accept;

    // Datapath step and sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_shl;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_data;

    // Decode operand signedness, magnitudes and the early-out special cases
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        a_signed     = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                       (req_op == OP_DIV)  || (req_op == OP_REM);
        b_signed     = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        sign_a       = a_signed & req_a[XLEN-1];
        sign_b       = b_signed & req_b[XLEN-1];
        mag_a        = sign_a ? -req_a : req_a;
        mag_b        = sign_b ? -req_b : req_b;
        is_special   = 1'b0;
        special_data = '0;
        if (req_op[2] && (req_b == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            is_special   = 1'b1;
            special_data = req_op[1] ? req_a : ALL_ONES;
        end else if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
                     (req_a == INT_MIN) && (req_b == ALL_ONES)) begin
            // Signed overflow: quotient is the dividend, remainder is zero
            is_special   = 1'b1;
            special_data = (req_op == OP_DIV) ? req_a : '0;
        end
    end

    // Next-state and handshake outputs; kill overrides everything
    always_comb begin
        state_nxt  = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = SYS_reset_n;
                busy      = 1'b0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = is_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (kill) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
        end
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_shl  = {acc_q, 1'b0};
        div_diff = div_shl[2*XLEN:XLEN] - {1'b0, mag_b_q};
        if (div_diff[XLEN]) div_next = div_shl[2*XLEN-1:0];
        else                div_next = {div_diff[XLEN-1:0], div_shl[XLEN-1:1], 1'b1};
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        prod_fix = neg_q     ? -acc_q                  : acc_q;
        quot_fix = neg_q     ? -acc_q[XLEN-1:0]        : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN]   : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_data = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_data = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_data = quot_fix;
            default:                      fix_data = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!SYS_reset_n) state_q <= S_IDLE;
        else              state_q <= state_nxt;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            op_q      <= '0;
            acc_q     <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else if (accept) begin
            op_q      <= req_op;
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            mag_b_q   <= mag_b;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt_q     <= CW'(XLEN-1);
            resp_tag  <= req_tag;
            if (is_special) resp_data <= special_data;
        end else if (!kill) begin
            case (state_q)
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: resp_data <= fix_data;
                default: ;
            endcase
        end
    end

endmodule
